// File: rtl/bcd_scan_display.sv
// bcd_scan_display
// Drives a 4-digit, common-anode, multiplexed 7-segment display from four
// BCD digits produced by a cascaded decade-counter chain.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-low reset
//   digits       four BCD digits, [3:0] = digit0 (LSD) ... [15:12] = digit3 (MSD)
//   blank_en     1 = suppress leading zeros on digits 3..1
//   an           active-low digit enables, an[i] drives digit i
//   seg          active-low segments, bit order {g,f,e,d,c,b,a}
//   frame_start  one-cycle pulse on each edge that snapshots digits
//
// SCAN_DIV sets how many clk cycles each digit slot stays lit (>= 1).

module bcd_scan_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic        blank_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        frame_start
);

   // A divider of 1 still needs a one-bit counter that simply stays at zero.
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             frame_start_q, frame_start_d;

   logic             tick;
   logic             snap;
   logic [3:0]       cur_digit;
   logic [6:0]       cur_seg;
   logic             lz3, lz2, lz1;
   logic             blank_slot;

   // Prescaler, scan index and the per-frame snapshot. Digits are only
   // captured as the last slot finishes, so a carry rippling through the
   // counter chain mid-frame never shows up as a torn reading.
   always_comb begin
      tick          = (cnt_q == CNT_W'(SCAN_DIV - 1));
      snap          = tick && (idx_q == 2'd3);
      cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d         = tick ? idx_q + 2'd1 : idx_q;
      shadow_d      = snap ? digits : shadow_q;
      frame_start_d = snap;
   end

   // Select the digit of the current slot from the snapshot.
   always_comb begin
      cur_digit = shadow_q[3:0];
      case (idx_q)
         2'd0: cur_digit = shadow_q[3:0];
         2'd1: cur_digit = shadow_q[7:4];
         2'd2: cur_digit = shadow_q[11:8];
         2'd3: cur_digit = shadow_q[15:12];
         default: cur_digit = shadow_q[3:0];
      endcase
   end

   // Active-low gfedcba decode; any non-BCD code shows a dash.
   always_comb begin
      cur_seg = 7'b0111111;
      case (cur_digit)
         4'd0: cur_seg = 7'b1000000;
         4'd1: cur_seg = 7'b1111001;
         4'd2: cur_seg = 7'b0100100;
         4'd3: cur_seg = 7'b0110000;
         4'd4: cur_seg = 7'b0011001;
         4'd5: cur_seg = 7'b0010010;
         4'd6: cur_seg = 7'b0000010;
         4'd7: cur_seg = 7'b1111000;
         4'd8: cur_seg = 7'b0000000;
         4'd9: cur_seg = 7'b0010000;
         default: cur_seg = 7'b0111111;
      endcase
   end

   // Leading-zero blanking works from the snapshot but honours blank_en live.
   // Invalid codes are nonzero, so a dash stops the blanking run.
   always_comb begin
      lz3        = (shadow_q[15:12] == 4'd0);
      lz2        = lz3 && (shadow_q[11:8] == 4'd0);
      lz1        = lz2 && (shadow_q[7:4] == 4'd0);
      blank_slot = 1'b0;
      case (idx_q)
         2'd3: blank_slot = lz3;
         2'd2: blank_slot = lz2;
         2'd1: blank_slot = lz1;
         default: blank_slot = 1'b0;
      endcase
      blank_slot = blank_slot && blank_en;
   end

   // Registered output stage, one cycle behind the scan index.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      if (!blank_slot) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = cur_seg;
      end
   end

   // State registers; reset wins over every other update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         shadow_q      <= 16'h0000;
         an_q          <= 4'b1111;
         seg_q         <= 7'b1111111;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display
// Directed bench for bcd_scan_display. Two instances share all inputs:
// dut4 (SCAN_DIV=4) carries most of the sequence, dut1 (SCAN_DIV=1)
// exercises the fastest scan rate after the final reset.

module tb_bcd_scan_display;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] digits;
   logic        blank_en;
   logic [3:0]  an4, an1;
   logic [6:0]  seg4, seg1;
   logic        fs4, fs1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_scan_display #(.SCAN_DIV(4)) dut4 (
      .clk         (clk),
      .reset       (reset),
      .digits      (digits),
      .blank_en    (blank_en),
      .an          (an4),
      .seg         (seg4),
      .frame_start (fs4)
   );

   bcd_scan_display #(.SCAN_DIV(1)) dut1 (
      .clk         (clk),
      .reset       (reset),
      .digits      (digits),
      .blank_en    (blank_en),
      .an          (an1),
      .seg         (seg1),
      .frame_start (fs1)
   );

   // Drive all inputs at once, away from the clock edge.
   task automatic applyStimulus(input logic r, input logic [15:0] d, input logic be);
      reset    = r;
      digits   = d;
      blank_en = be;
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Walk one full frame of dut4 (16 edges) starting just after a snapshot
   // edge. Slot s expects an exp_an[4s+:4] and seg exp_seg[7s+:7];
   // frame_start is expected only on the last edge of the frame.
   task automatic checkFrame(input string tag, input logic [15:0] exp_an,
                             input logic [27:0] exp_seg, input logic chg,
                             input logic [15:0] new_digits);
      int s;
      for (int c = 0; c < 16; c++) begin
         step(1);
         s = c / 4;
         checkOutput($sformatf("%s an c%0d", tag, c), {4'b0, an4}, {4'b0, exp_an[4*s +: 4]});
         checkOutput($sformatf("%s seg c%0d", tag, c), {1'b0, seg4}, {1'b0, exp_seg[7*s +: 7]});
         checkOutput($sformatf("%s fs c%0d", tag, c), {7'b0, fs4}, {7'b0, (c == 15)});
         if (chg && c == 5) digits = new_digits;
      end
   endtask

   // Expected dut1 outputs over the first 8 edges after the final reset.
   logic [3:0] exp_an1  [8] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111,
                                4'b1110, 4'b1101, 4'b1111, 4'b1111};
   logic [6:0] exp_seg1 [8] = '{7'h40, 7'h7F, 7'h7F, 7'h7F,
                                7'h40, 7'h3F, 7'h7F, 7'h7F};
   logic       exp_fs1  [8] = '{1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      // Hold reset for three edges.
      applyStimulus(1'b0, 16'h1234, 1'b0);
      step(3);
      checkOutput("rst an4", {4'b0, an4}, 8'h0F);
      checkOutput("rst seg4", {1'b0, seg4}, 8'h7F);
      checkOutput("rst fs4", {7'b0, fs4}, 8'h00);
      checkOutput("rst an1", {4'b0, an1}, 8'h0F);
      checkOutput("rst fs1", {7'b0, fs1}, 8'h00);

      // First post-reset cycle shows slot 0 of an all-zero snapshot.
      reset = 1'b1;
      step(1);
      checkOutput("post an4", {4'b0, an4}, 8'h0E);
      checkOutput("post seg4", {1'b0, seg4}, 8'h40);
      checkOutput("post fs4", {7'b0, fs4}, 8'h00);

      // No snapshot until the 16th edge.
      step(14);
      checkOutput("e15 fs4", {7'b0, fs4}, 8'h00);
      step(1);
      checkOutput("e16 fs4", {7'b0, fs4}, 8'h01);
      checkOutput("e16 an4", {4'b0, an4}, 8'h07);
      checkOutput("e16 seg4", {1'b0, seg4}, 8'h40);

      // 1234 displayed; digits change to 5678 mid-frame without tearing.
      checkFrame("f1234", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 16'h5678);
      checkFrame("f5678", 16'h7BDE, {7'h12, 7'h02, 7'h78, 7'h00}, 1'b0, 16'h0000);

      // Request 0070 with blanking; the current frame still shows 5678.
      applyStimulus(1'b1, 16'h0070, 1'b1);
      checkFrame("f5678b", 16'h7BDE, {7'h12, 7'h02, 7'h78, 7'h00}, 1'b0, 16'h0000);
      checkFrame("f0070b", 16'hFFDE, {7'h7F, 7'h7F, 7'h78, 7'h40}, 1'b0, 16'h0000);

      // Blanking off takes effect immediately; 00A0 waits for the next snapshot.
      applyStimulus(1'b1, 16'h00A0, 1'b0);
      checkFrame("f0070", 16'h7BDE, {7'h40, 7'h40, 7'h78, 7'h40}, 1'b0, 16'h0000);
      blank_en = 1'b1;
      checkFrame("f00A0b", 16'hFFDE, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 1'b0, 16'h0000);

      // Reset while dut4 is in slot 2 (idx advanced to 2 on edge 120).
      step(9);
      reset = 1'b0;
      step(1);
      checkOutput("mrst an4", {4'b0, an4}, 8'h0F);
      checkOutput("mrst seg4", {1'b0, seg4}, 8'h7F);
      checkOutput("mrst fs4", {7'b0, fs4}, 8'h00);
      checkOutput("mrst an1", {4'b0, an1}, 8'h0F);
      checkOutput("mrst seg1", {1'b0, seg1}, 8'h7F);
      reset = 1'b1;

      // Restart: dut4 scans slot 0 for four edges with a cleared snapshot,
      // dut1 advances every edge and snapshots every fourth.
      for (int k = 1; k <= 8; k++) begin
         step(1);
         checkOutput($sformatf("d1 an k%0d", k), {4'b0, an1}, {4'b0, exp_an1[k-1]});
         checkOutput($sformatf("d1 seg k%0d", k), {1'b0, seg1}, {1'b0, exp_seg1[k-1]});
         checkOutput($sformatf("d1 fs k%0d", k), {7'b0, fs1}, {7'b0, exp_fs1[k-1]});
         checkOutput($sformatf("d4 fs k%0d", k), {7'b0, fs4}, 8'h00);
         if (k == 1 || k == 4) begin
            checkOutput($sformatf("d4 an k%0d", k), {4'b0, an4}, 8'h0E);
            checkOutput($sformatf("d4 seg k%0d", k), {1'b0, seg4}, 8'h40);
         end
         if (k == 5) begin
            checkOutput("d4 an k5", {4'b0, an4}, 8'h0F);
            checkOutput("d4 seg k5", {1'b0, seg4}, 8'h7F);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
